jacobi_pair_scheduler: RTL and testbench

// - Sequences Jacobi sweeps: emits the (p,q) index pairs of each parallel round, in

---
 rtl/jacobi_pair_scheduler_pkg.sv | 29 ++
 rtl/jacobi_pair_scheduler_if.sv | 49 ++++
 rtl/jacobi_rr_order.sv | 86 ++++++++
 rtl/jacobi_pair_scheduler.sv | 165 ++++++++++++++++
 tb/tb_jacobi_pair_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/jacobi_pair_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler_pkg
// Shared constants and types for the Jacobi (p,q) pair scheduler.
//   JACOBI_N           default matrix dimension (even, >= 4)
//   JACOBI_N_PAIRS     disjoint pairs per parallel round
//   JACOBI_MAX_SWEEPS  default hard sweep limit
//   sched_fsm_t        scheduler FSM state encoding
//   pair_t             one (p,q) index pair at the default dimension
// -----------------------------------------------------------------------------
package jacobi_pair_scheduler_pkg;

  localparam int JACOBI_N          = 8;
  localparam int JACOBI_N_PAIRS    = JACOBI_N / 2;
  localparam int JACOBI_MAX_SWEEPS = 10;
  localparam int JACOBI_LW         = $clog2(JACOBI_N);

  typedef enum logic [1:0] {
    SCHED_IDLE       = 2'd0,
    SCHED_ISSUE      = 2'd1,
    SCHED_WAIT_ROUND = 2'd2,
    SCHED_DONE       = 2'd3
  } sched_fsm_t;

  typedef struct packed {
    logic [JACOBI_LW-1:0] p;
    logic [JACOBI_LW-1:0] q;
  } pair_t;

endpackage

// File: rtl/jacobi_pair_scheduler_if.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler_if
// Bundles the scheduler's host control, pair stream and datapath feedback.
//   host      : start_i, busy_o, done_o, conv_o, sweep_o
//   pair bus  : pair_vld_o / pair_rdy_i handshake carrying pair_p_o, pair_q_o,
//               pair_idx_o, pair_last_o, round_o
//   datapath  : round_done_i, converged_i
// Modport master = scheduler side, slave = environment side.
// -----------------------------------------------------------------------------
interface jacobi_pair_scheduler_if
  import jacobi_pair_scheduler_pkg::*;
#(
  parameter int N          = JACOBI_N,
  parameter int MAX_SWEEPS = JACOBI_MAX_SWEEPS
) ();

  localparam int LW = $clog2(N);
  localparam int PW = $clog2(N / 2);
  localparam int RW = $clog2(N - 1);
  localparam int SW = $clog2(MAX_SWEEPS + 1);

  logic          start_i;
  logic          pair_vld_o;
  logic          pair_rdy_i;
  logic [LW-1:0] pair_p_o;
  logic [LW-1:0] pair_q_o;
  logic [PW-1:0] pair_idx_o;
  logic          pair_last_o;
  logic [RW-1:0] round_o;
  logic [SW-1:0] sweep_o;
  logic          round_done_i;
  logic          converged_i;
  logic          busy_o;
  logic          done_o;
  logic          conv_o;

  modport master (
    input  start_i, pair_rdy_i, round_done_i, converged_i,
    output pair_vld_o, pair_p_o, pair_q_o, pair_idx_o, pair_last_o,
           round_o, sweep_o, busy_o, done_o, conv_o
  );

  modport slave (
    output start_i, pair_rdy_i, round_done_i, converged_i,
    input  pair_vld_o, pair_p_o, pair_q_o, pair_idx_o, pair_last_o,
           round_o, sweep_o, busy_o, done_o, conv_o
  );

endinterface

// File: rtl/jacobi_rr_order.sv
// -----------------------------------------------------------------------------
// jacobi_rr_order
// Round-robin (circle method) ordering for parallel Jacobi sweeps.
// Holds the top/bot index rows; slot k pairs top[k] with bot[k].
//   clk, rst_n  clock / async active-low reset (reset = initial ordering)
//   init_i      reload initial ordering top[k]=k, bot[k]=N-1-k
//   rotate_i    advance one round; top[0] stays fixed
//   slot_i      slot to present
//   pair_p_o    min(top[slot], bot[slot])
//   pair_q_o    max(top[slot], bot[slot])
// -----------------------------------------------------------------------------
module jacobi_rr_order
  import jacobi_pair_scheduler_pkg::*;
#(
  parameter int N = JACOBI_N
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_i,
  input  logic                       rotate_i,
  input  logic [$clog2(N/2)-1:0]     slot_i,
  output logic [$clog2(N)-1:0]       pair_p_o,
  output logic [$clog2(N)-1:0]       pair_q_o
);

  localparam int HALF = N / 2;
  localparam int LW   = $clog2(N);

  logic [LW-1:0] top_q   [HALF];
  logic [LW-1:0] bot_q   [HALF];
  logic [LW-1:0] top_d   [HALF];
  logic [LW-1:0] bot_d   [HALF];
  logic [LW-1:0] top_rot [HALF];
  logic [LW-1:0] bot_rot [HALF];

  // Circle rotation: indices flow right along the top row (after the fixed
  // top[0]), drop into the bottom row at the far end, and flow left along the
  // bottom row back up into top[1].
  for (genvar gi = 0; gi < HALF; gi++) begin : g_slot
    if (gi == 0) begin : g_top_fixed
      assign top_rot[gi] = top_q[0];
    end else if (gi == 1) begin : g_top_wrap
      assign top_rot[gi] = bot_q[0];
    end else begin : g_top_shift
      assign top_rot[gi] = top_q[gi-1];
    end

    if (gi == HALF - 1) begin : g_bot_wrap
      assign bot_rot[gi] = top_q[HALF-1];
    end else begin : g_bot_shift
      assign bot_rot[gi] = bot_q[gi+1];
    end

    assign top_d[gi] = init_i   ? LW'(gi)
                     : rotate_i ? top_rot[gi]
                     :            top_q[gi];
    assign bot_d[gi] = init_i   ? LW'(N - 1 - gi)
                     : rotate_i ? bot_rot[gi]
                     :            bot_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HALF; k++) begin
        top_q[k] <= LW'(k);
        bot_q[k] <= LW'(N - 1 - k);
      end
    end else begin
      for (int k = 0; k < HALF; k++) begin
        top_q[k] <= top_d[k];
        bot_q[k] <= bot_d[k];
      end
    end
  end

  logic [LW-1:0] sel_top;
  logic [LW-1:0] sel_bot;

  assign sel_top  = top_q[slot_i];
  assign sel_bot  = bot_q[slot_i];
  // The rotation scatters small and large indices across both rows, so order
  // each pair explicitly to guarantee p < q.
  assign pair_p_o = (sel_top < sel_bot) ? sel_top : sel_bot;
  assign pair_q_o = (sel_top < sel_bot) ? sel_bot : sel_top;

endmodule

// File: rtl/jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler
// Sequences Jacobi sweeps: issues the N/2 disjoint (p,q) pairs of each round
// over a valid/ready stream, advances rounds on round_done_i, and finishes on
// convergence (sampled at sweep end) or after MAX_SWEEPS sweeps.
//   clk, rst_n  clock / async active-low reset
//   bus         jacobi_pair_scheduler_if.master:
//                 start_i      begin decomposition (IDLE only)
//                 pair_*       pair stream, pair_vld_o/pair_rdy_i handshake
//                 round_o      round within sweep, sweep_o completed sweeps
//                 round_done_i datapath finished current round
//                 converged_i  convergence level, sampled at sweep end
//                 busy_o/done_o/conv_o  host status
// -----------------------------------------------------------------------------
module jacobi_pair_scheduler
  import jacobi_pair_scheduler_pkg::*;
#(
  parameter int N          = JACOBI_N,
  parameter int MAX_SWEEPS = JACOBI_MAX_SWEEPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jacobi_pair_scheduler_if.master  bus
);

  localparam int HALF = N / 2;
  localparam int LW   = $clog2(N);
  localparam int PW   = $clog2(N / 2);
  localparam int RW   = $clog2(N - 1);
  localparam int SW   = $clog2(MAX_SWEEPS + 1);

  localparam logic [PW-1:0] LAST_IDX    = PW'(HALF - 1);
  localparam logic [RW-1:0] LAST_ROUND  = RW'(N - 2);
  localparam logic [SW-1:0] SWEEP_LIMIT = SW'(MAX_SWEEPS);

  sched_fsm_t    state_q, state_d;
  logic [PW-1:0] idx_q,   idx_d;
  logic [RW-1:0] round_q, round_d;
  logic [SW-1:0] sweep_q, sweep_d;
  logic          busy_q,  busy_d;
  logic          conv_q,  conv_d;

  logic          order_init;
  logic          order_rotate;
  logic          issuing;
  logic          last_slot;
  logic [SW-1:0] sweep_inc;
  logic [LW-1:0] slot_p;
  logic [LW-1:0] slot_q;

  jacobi_rr_order #(
    .N (N)
  ) u_order (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_i   (order_init),
    .rotate_i (order_rotate),
    .slot_i   (idx_q),
    .pair_p_o (slot_p),
    .pair_q_o (slot_q)
  );

  assign issuing   = (state_q == SCHED_ISSUE);
  assign last_slot = (idx_q == LAST_IDX);
  // Sweep count cannot exceed MAX_SWEEPS: the limit check below ends the run
  // on the increment that reaches it.
  assign sweep_inc = sweep_q + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      idx_q   <= '0;
      round_q <= '0;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    round_d      = round_q;
    sweep_d      = sweep_q;
    busy_d       = busy_q;
    conv_d       = conv_q;
    order_init   = 1'b0;
    order_rotate = 1'b0;

    unique case (state_q)
      SCHED_IDLE: begin
        if (bus.start_i) begin
          order_init = 1'b1;
          idx_d      = '0;
          round_d    = '0;
          sweep_d    = '0;
          conv_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = SCHED_ISSUE;
        end
      end

      SCHED_ISSUE: begin
        if (bus.pair_rdy_i) begin
          if (last_slot) begin
            idx_d   = '0;
            state_d = SCHED_WAIT_ROUND;
          end else begin
            idx_d = idx_q + PW'(1);
          end
        end
      end

      SCHED_WAIT_ROUND: begin
        if (bus.round_done_i) begin
          order_rotate = 1'b1;
          if (round_q != LAST_ROUND) begin
            round_d = round_q + RW'(1);
            state_d = SCHED_ISSUE;
          end else begin
            // Sweep boundary: the only point where converged_i is honoured.
            // Convergence takes priority over the limit for the conv_o cause.
            round_d = '0;
            sweep_d = sweep_inc;
            if (bus.converged_i || (sweep_inc == SWEEP_LIMIT)) begin
              conv_d  = bus.converged_i;
              state_d = SCHED_DONE;
            end else begin
              state_d = SCHED_ISSUE;
            end
          end
        end
      end

      SCHED_DONE: begin
        busy_d  = 1'b0;
        state_d = SCHED_IDLE;
      end

      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  // Pair fields are forced to zero outside ISSUE so idle outputs read as 0.
  assign bus.pair_vld_o  = issuing;
  assign bus.pair_p_o    = issuing ? slot_p : '0;
  assign bus.pair_q_o    = issuing ? slot_q : '0;
  assign bus.pair_idx_o  = idx_q;
  assign bus.pair_last_o = issuing && last_slot;
  assign bus.round_o     = round_q;
  assign bus.sweep_o     = sweep_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = (state_q == SCHED_DONE);
  assign bus.conv_o      = conv_q;

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jacobi_pair_scheduler
// Directed bench for jacobi_pair_scheduler at N=8, MAX_SWEEPS=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_jacobi_pair_scheduler;
  import jacobi_pair_scheduler_pkg::*;

  localparam int N  = 8;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jacobi_pair_scheduler_if #(.N(N), .MAX_SWEEPS(MS)) bus ();

  jacobi_pair_scheduler #(.N(N), .MAX_SWEEPS(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-derived circle-method ordering, encoded as p*10+q per slot.
  int exp_pq [7][4] = '{
    '{ 7, 16, 25, 34},   // round 0
    '{ 6, 57, 14, 23},   // round 1
    '{ 5, 46, 37, 12},   // round 2
    '{ 4, 35, 26, 17},   // round 3
    '{ 3, 24, 15, 67},   // round 4
    '{ 2, 13, 47, 56},   // round 5
    '{ 1, 27, 36, 45}    // round 6
  };

  int seen [8][8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input int r, input int s, input string pfx);
    int   ep, eq;
    pair_t obs;
    ep = exp_pq[r][s] / 10;
    eq = exp_pq[r][s] % 10;
    obs.p = bus.pair_p_o;
    obs.q = bus.pair_q_o;
    check($sformatf("%s r%0d s%0d vld", pfx, r, s), 32'(bus.pair_vld_o), 32'd1);
    check($sformatf("%s r%0d s%0d p", pfx, r, s), 32'(obs.p), 32'(ep));
    check($sformatf("%s r%0d s%0d q", pfx, r, s), 32'(obs.q), 32'(eq));
    check($sformatf("%s r%0d s%0d idx", pfx, r, s), 32'(bus.pair_idx_o), 32'(s));
    check($sformatf("%s r%0d s%0d last", pfx, r, s), 32'(bus.pair_last_o), (s == 3) ? 32'd1 : 32'd0);
    check($sformatf("%s r%0d s%0d round", pfx, r, s), 32'(bus.round_o), 32'(r));
    $display("[TB] round %0d slot %0d pair (%0d,%0d)", r, s, obs.p, obs.q);
  endtask

  // Issue all four slots of round r. stall: slot held with rdy=0 for three
  // cycles. poke: slot during which start_i and round_done_i are pulsed.
  task automatic issue_round(input int r, input int stall, input int poke);
    for (int s = 0; s < 4; s++) begin
      if (s == stall) begin
        bus.pair_rdy_i = 1'b0;
        repeat (3) begin
          check_pair(r, s, "stall");
          @(negedge clk);
        end
        bus.pair_rdy_i = 1'b1;
      end
      check_pair(r, s, "issue");
      seen[bus.pair_p_o][bus.pair_q_o]++;
      if (s == poke) begin
        bus.start_i      = 1'b1;
        bus.round_done_i = 1'b1;
      end
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.round_done_i = 1'b0;
    end
    check($sformatf("wait r%0d vld", r), 32'(bus.pair_vld_o), 32'd0);
    check($sformatf("wait r%0d p", r), 32'(bus.pair_p_o), 32'd0);
  endtask

  task automatic finish_round(input logic conv);
    bus.converged_i  = conv;
    bus.round_done_i = 1'b1;
    @(negedge clk);
    bus.round_done_i = 1'b0;
    bus.converged_i  = 1'b0;
  endtask

  task automatic do_start(input string tag);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    check({tag, " sweep"}, 32'(bus.sweep_o), 32'd0);
    check({tag, " conv"}, 32'(bus.conv_o), 32'd0);
    $display("[TB] start accepted (%s)", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int uniq;

    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.pair_rdy_i   = 1'b0;
    bus.round_done_i = 1'b0;
    bus.converged_i  = 1'b0;
    foreach (seen[i, j]) seen[i][j] = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst vld",   32'(bus.pair_vld_o),  32'd0);
    check("rst p",     32'(bus.pair_p_o),    32'd0);
    check("rst q",     32'(bus.pair_q_o),    32'd0);
    check("rst idx",   32'(bus.pair_idx_o),  32'd0);
    check("rst last",  32'(bus.pair_last_o), 32'd0);
    check("rst round", 32'(bus.round_o),     32'd0);
    check("rst sweep", 32'(bus.sweep_o),     32'd0);
    check("rst busy",  32'(bus.busy_o),      32'd0);
    check("rst done",  32'(bus.done_o),      32'd0);
    check("rst conv",  32'(bus.conv_o),      32'd0);
    $display("[TB] reset state checked");
    rst_n = 1'b1;
    @(negedge clk);

    // ---- idle: round_done / rdy / converged have no effect ----
    bus.round_done_i = 1'b1;
    bus.pair_rdy_i   = 1'b1;
    bus.converged_i  = 1'b1;
    @(negedge clk);
    bus.round_done_i = 1'b0;
    bus.converged_i  = 1'b0;
    @(negedge clk);
    check("idle vld",   32'(bus.pair_vld_o), 32'd0);
    check("idle busy",  32'(bus.busy_o),     32'd0);
    check("idle done",  32'(bus.done_o),     32'd0);
    check("idle round", 32'(bus.round_o),    32'd0);
    $display("[TB] idle inputs ignored");

    // ---- run 1, sweep 0: stall on (2,5); converged=1 mid-sweep is ignored ----
    do_start("run1");
    for (int r = 0; r < 7; r++) begin
      issue_round(r, (r == 0) ? 2 : -1, -1);
      if (r == 3) begin
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("wait start ignored vld",   32'(bus.pair_vld_o), 32'd0);
        check("wait start ignored round", 32'(bus.round_o),    32'd3);
        $display("[TB] start during WAIT_ROUND ignored");
      end
      finish_round((r < 6) ? 1'b1 : 1'b0);
    end
    uniq = 0;
    for (int p = 0; p < 8; p++)
      for (int q = p + 1; q < 8; q++)
        if (seen[p][q] == 1) uniq++;
    check("sweep0 unique pairs", 32'(uniq), 32'd28);
    check("sweep0 end sweep", 32'(bus.sweep_o), 32'd1);
    check("sweep0 end done",  32'(bus.done_o),  32'd0);
    check("sweep0 end busy",  32'(bus.busy_o),  32'd1);
    $display("[TB] sweep 0 complete, %0d unique pairs", uniq);

    // ---- run 1, sweep 1: sweep limit reached ----
    for (int r = 0; r < 7; r++) begin
      issue_round(r, -1, -1);
      finish_round(1'b0);
    end
    check("limit done",  32'(bus.done_o),     32'd1);
    check("limit conv",  32'(bus.conv_o),     32'd0);
    check("limit sweep", 32'(bus.sweep_o),    32'd2);
    check("limit vld",   32'(bus.pair_vld_o), 32'd0);
    check("limit round", 32'(bus.round_o),    32'd0);
    @(negedge clk);
    check("limit+1 done",  32'(bus.done_o),  32'd0);
    check("limit+1 busy",  32'(bus.busy_o),  32'd0);
    check("limit+1 sweep", 32'(bus.sweep_o), 32'd2);
    $display("[TB] run 1 done by sweep limit");

    // ---- run 2: start/round_done pulsed during ISSUE; converge at sweep 0 ----
    do_start("run2");
    for (int r = 0; r < 7; r++) begin
      issue_round(r, -1, (r == 0) ? 1 : -1);
      finish_round((r == 6) ? 1'b1 : 1'b0);
    end
    check("conv done",  32'(bus.done_o),  32'd1);
    check("conv conv",  32'(bus.conv_o),  32'd1);
    check("conv sweep", 32'(bus.sweep_o), 32'd1);
    @(negedge clk);
    check("conv+1 done", 32'(bus.done_o), 32'd0);
    check("conv+1 busy", 32'(bus.busy_o), 32'd0);
    check("conv+1 conv", 32'(bus.conv_o), 32'd1);
    $display("[TB] run 2 done by convergence");

    // ---- run 3: async reset mid-round 3, then restart ----
    do_start("run3");
    for (int r = 0; r < 3; r++) begin
      issue_round(r, -1, -1);
      finish_round(1'b0);
    end
    check_pair(3, 0, "pre-reset");
    @(negedge clk);
    check_pair(3, 1, "pre-reset");
    rst_n = 1'b0;
    #1;
    check("async rst vld",   32'(bus.pair_vld_o), 32'd0);
    check("async rst idx",   32'(bus.pair_idx_o), 32'd0);
    check("async rst round", 32'(bus.round_o),    32'd0);
    check("async rst busy",  32'(bus.busy_o),     32'd0);
    check("async rst done",  32'(bus.done_o),     32'd0);
    @(negedge clk);
    check("rst hold done", 32'(bus.done_o), 32'd0);
    check("rst hold conv", 32'(bus.conv_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] async reset mid-round 3 applied");
    do_start("run4");
    check_pair(0, 0, "restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
